dcache_req_arbiter: RTL and testbench
=====================================

DCACHE_REQ_ARBITER -- requirements
Module: dcache_req_arbiter

Interface
REQ-001 Parameter NR_PORTS, default 3: number of requesters sharing one D$ request port; legal range 2..8.
REQ-002 Parameter ADDR_W, default 12: request address width (index bits).
REQ-003 Parameter DATA_W, default 64: data width; byte-enable width is DATA_W/8.
REQ-004 Parameter MAX_OUT, default 4: maximum outstanding reads; must be a power of two, at least 2.
REQ-005 Ports, clock and reset first:
  clk_i  in  1  clock; the only clock; all state updates on its rising edge.
  rst_ni  in  1  asynchronous active-low reset.
  req_i  in  NR_PORTS  per-port request valid.
  we_i  in  NR_PORTS  per-port write flag (1 = store, 0 = load).
  addr_i  in  NR_PORTS*ADDR_W  per-port address; port p occupies slice p.
  wdata_i  in  NR_PORTS*DATA_W  per-port write data.
  be_i  in  NR_PORTS*DATA_W/8  per-port byte enables.
  gnt_o  out  NR_PORTS  per-port grant, one-hot or zero.
  rvalid_o  out  NR_PORTS  per-port read-data valid, one-hot or zero.
  rdata_o  out  DATA_W  read data, driven to all ports.
  cache_req_o  out  1  request to the D$.
  cache_we_o, cache_addr_o, cache_wdata_o, cache_be_o  out  1/ADDR_W/DATA_W/DATA_W/8  fields of the selected port.
  cache_gnt_i  in  1  D$ accepts the current request.
  cache_rvalid_i  in  1  D$ returns load data, in order.
  cache_rdata_i  in  DATA_W  D$ load data.
  outstanding_o  out  $clog2(MAX_OUT)+1  reads granted but not yet returned.
  err_o  out  1  sticky protocol error.

Function
REQ-006 Arbitration is round-robin: a priority pointer rr_q selects the first requesting port at or after rr_q, wrapping modulo NR_PORTS.
REQ-007 FSM states are IDLE and LOCKED; the state is IDLE out of reset.
REQ-008 In IDLE with any req_i set and no read stall, the arbiter selects a winner and drives cache_req_o=1 with the winner's fields in the same cycle.
REQ-009 If cache_gnt_i=0 in that cycle, the FSM moves to LOCKED, holding the winner index in lock_q.
REQ-010 In LOCKED, the fields of lock_q are driven regardless of the other ports; the FSM returns to IDLE on the first cycle where cache_gnt_i=1.
REQ-011 gnt_o[w] equals cache_gnt_i AND cache_req_o for the selected port w; no other bit of gnt_o is set.
REQ-012 On each grant, rr_q becomes (w+1) mod NR_PORTS; otherwise rr_q holds.
REQ-013 If the locked requester drops req_i before the grant, cache_req_o still stays high until cache_gnt_i; that grant is counted, and a dropped request sets err_o.
REQ-014 Each granted read pushes w into an in-order ID FIFO of depth MAX_OUT; a granted write pushes nothing.
REQ-015 When outstanding_o==MAX_OUT, no new read is presented; a write from the round-robin winner is still presented.
REQ-016 Read stall: if the round-robin winner is a read while the FIFO is full, cache_req_o=0 and no port is granted. There is no skipping.
REQ-017 cache_rvalid_i pops the FIFO head h: rvalid_o[h]=1 and rdata_o=cache_rdata_i in the same cycle, zero latency.
REQ-018 A simultaneous push and pop in one cycle leaves outstanding_o unchanged, and the FIFO entries stay correct.
REQ-019 A return of rdata in the same cycle as the read's grant (pop of an empty FIFO) is illegal and sets err_o.
REQ-020 Any cache_rvalid_i while outstanding_o==0 sets err_o and produces no rvalid_o.
REQ-021 err_o is sticky until reset.
REQ-022 When cache_req_o=0, rdata_o and the cache_* fields are don't-care, but they must not be X.

Reset
REQ-023 Asynchronous assertion of rst_ni resets the following at once: FSM to IDLE, rr_q=0, lock_q=0, FIFO pointers and count=0, err_o=0.
REQ-024 During reset, all outputs are 0.
REQ-025 Reset in the middle of a transaction discards all outstanding IDs.
REQ-026 Deassertion of rst_ni is synchronous to clk_i; the first request can be presented in the first cycle after deassertion.

Verification
REQ-027 Contention: ports 0, 1 and 2 request reads continuously, cache_gnt_i=1 each cycle -> grants go to 0,1,2,0,1,2; cache_rvalid_i one cycle later -> rvalid_o follows the same order.
REQ-028 Lock: port 1 requests, cache_gnt_i=0 for 3 cycles, and port 0 raises req_i in cycle 2 -> cache_addr_o stays at port 1's address; gnt_o=3'b010 in cycle 4.
REQ-029 Full FIFO: MAX_OUT=4, four reads granted with no return -> outstanding_o=4; a fifth read is not presented, but a write from the winning port is granted; one rvalid -> the read is presented the next cycle.
REQ-030 Push and pop together: outstanding_o=2, a read grant coincides with cache_rvalid_i -> outstanding_o stays 2; the popped ID is the oldest.
REQ-031 Errors: cache_rvalid_i with outstanding_o=0 -> err_o=1 next cycle and stays 1; rvalid_o stays 0.
REQ-032 Reset in the middle of a transaction: assert rst_ni low with 3 reads outstanding and state LOCKED -> all outputs 0 at once; after release, state IDLE and outstanding_o=0.

Source files
------------

// File: rtl/dcache_req_arbiter_if.sv
// Requester-side and D$-side signals of the data-cache request arbiter.
// The arbiter connects through the slave modport; the environment drives through master.
interface dcache_req_arbiter_if #(
    parameter int NR_PORTS = 3,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 64,
    parameter int MAX_OUT  = 4
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic [NR_PORTS-1:0]        req_i;
    logic [NR_PORTS-1:0]        we_i;
    logic [NR_PORTS*ADDR_W-1:0] addr_i;
    logic [NR_PORTS*DATA_W-1:0] wdata_i;
    logic [NR_PORTS*BE_W-1:0]   be_i;
    logic [NR_PORTS-1:0]        gnt_o;
    logic [NR_PORTS-1:0]        rvalid_o;
    logic [DATA_W-1:0]          rdata_o;

    logic                       cache_req_o;
    logic                       cache_we_o;
    logic [ADDR_W-1:0]          cache_addr_o;
    logic [DATA_W-1:0]          cache_wdata_o;
    logic [BE_W-1:0]            cache_be_o;
    logic                       cache_gnt_i;
    logic                       cache_rvalid_i;
    logic [DATA_W-1:0]          cache_rdata_i;

    logic [CNT_W-1:0]           outstanding_o;
    logic                       err_o;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        input  cache_gnt_i, cache_rvalid_i, cache_rdata_i,
        output gnt_o, rvalid_o, rdata_o,
        output cache_req_o, cache_we_o, cache_addr_o, cache_wdata_o, cache_be_o,
        output outstanding_o, err_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        output cache_gnt_i, cache_rvalid_i, cache_rdata_i,
        input  gnt_o, rvalid_o, rdata_o,
        input  cache_req_o, cache_we_o, cache_addr_o, cache_wdata_o, cache_be_o,
        input  outstanding_o, err_o
    );
endinterface

// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one D$ request port among NR_PORTS requesters,
// with request locking until grant and an in-order ID FIFO routing load data back.
module dcache_req_arbiter #(
    parameter int NR_PORTS = 3,
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 64,
    parameter int MAX_OUT  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    dcache_req_arbiter_if.slave   bus
);
    localparam int IDX_W = $clog2(NR_PORTS);
    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   rr_q;
    logic [IDX_W-1:0]   lock_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic [IDX_W-1:0]   fifo_q [MAX_OUT];

    logic               rr_hit;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   sel;
    logic               sel_we;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_be;
    logic               fifo_full;
    logic               cache_req;
    logic               grant;
    logic               push;
    logic               pop;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        cand   = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            cand = IDX_W'((int'(rr_q) + i) % NR_PORTS);
            if (!rr_hit && bus.req_i[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    assign sel       = (state_q == LOCKED) ? lock_q : rr_idx;
    assign sel_we    = bus.we_i[sel];
    assign sel_addr  = bus.addr_i[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_wdata = bus.wdata_i[int'(sel)*DATA_W +: DATA_W];
    assign sel_be    = bus.be_i[int'(sel)*BE_W +: BE_W];
    assign fifo_full = (cnt_q == CNT_W'(MAX_OUT));

    // A read winner facing a full FIFO stalls the port outright; lower-priority requesters are not tried.
    assign cache_req = rst_ni && ((state_q == LOCKED) ||
                                  (rr_hit && !(!bus.we_i[rr_idx] && fifo_full)));
    assign grant     = cache_req && bus.cache_gnt_i;
    assign push      = grant && !sel_we;
    assign pop       = bus.cache_rvalid_i && (cnt_q != '0);

    assign bus.cache_req_o   = cache_req;
    assign bus.cache_we_o    = cache_req && sel_we;
    assign bus.cache_addr_o  = cache_req ? sel_addr  : '0;
    assign bus.cache_wdata_o = cache_req ? sel_wdata : '0;
    assign bus.cache_be_o    = cache_req ? sel_be    : '0;
    assign bus.gnt_o         = grant ? (NR_PORTS'(1) << sel) : '0;
    assign bus.rvalid_o      = pop ? (NR_PORTS'(1) << fifo_q[rd_ptr_q]) : '0;
    assign bus.rdata_o       = pop ? bus.cache_rdata_i : '0;
    assign bus.outstanding_o = cnt_q;
    assign bus.err_o         = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            lock_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cache_req && !bus.cache_gnt_i) begin
                        state_q <= LOCKED;
                        lock_q  <= sel;
                    end
                end
                LOCKED: begin
                    if (bus.cache_gnt_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (grant)
                rr_q <= (sel == IDX_W'(NR_PORTS - 1)) ? '0 : sel + 1'b1;

            // Load data with nothing outstanding, or a locked requester withdrawing, is a protocol error.
            if ((bus.cache_rvalid_i && cnt_q == '0) ||
                (state_q == LOCKED && !bus.req_i[lock_q]))
                err_q <= 1'b1;

            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // NOTE: the ID storage has no reset; only the pointers and count qualify its contents.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= sel;
    end
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: directed scenarios plus a randomized
// run compared against a queue-based reference model of the arbitration rules.
module tb_dcache_req_arbiter;
    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int MO = 4;
    localparam int BW = DW / 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    dcache_req_arbiter_if #(.NR_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) bus ();

    dcache_req_arbiter #(.NR_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic mid();
        @(negedge clk_i);
    endtask

    task automatic drive_idle();
        bus.req_i          = '0;
        bus.we_i           = '0;
        bus.addr_i         = '0;
        bus.wdata_i        = '0;
        bus.be_i           = '0;
        bus.cache_gnt_i    = 1'b0;
        bus.cache_rvalid_i = 1'b0;
        bus.cache_rdata_i  = '0;
    endtask

    task automatic set_port(input int p, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] b);
        bus.we_i[p]             = we;
        bus.addr_i[p*AW +: AW]  = a;
        bus.wdata_i[p*DW +: DW] = d;
        bus.be_i[p*BW +: BW]    = b;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        bus.req_i = 3'b111;
        bus.we_i = 3'b000;
        bus.addr_i = {12'h0A3, 12'h0A2, 12'h0A1};
        bus.wdata_i = '1;
        bus.be_i = '1;
        bus.cache_gnt_i = 1'b1;
        bus.cache_rvalid_i = 1'b1;
        bus.cache_rdata_i = 64'hDEAD_BEEF_0000_1111;
        #12;
        n_checks++;
        if (bus.cache_req_o !== 1'b0 || bus.gnt_o !== 3'b000 || bus.rvalid_o !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_handshake req=%b gnt=%b rvalid=%b, want 0/000/000",
                     bus.cache_req_o, bus.gnt_o, bus.rvalid_o);
        end
        n_checks++;
        if (bus.outstanding_o !== 3'd0 || bus.err_o !== 1'b0 || bus.rdata_o !== 64'd0 ||
            bus.cache_addr_o !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_state outst=%0d err=%b rdata=%h addr=%h, want all 0",
                     bus.outstanding_o, bus.err_o, bus.rdata_o, bus.cache_addr_o);
        end
    endtask

    task automatic test_contention();
        logic [2:0]    exp_g;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        apply_reset();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(12'h100 + p), '0, '1);
        bus.cache_gnt_i = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.req_i          = (k < 6) ? 3'b111 : 3'b000;
            bus.cache_rvalid_i = (k > 0);
            exp_d              = 64'hA000 + DW'(k);
            bus.cache_rdata_i  = exp_d;
            mid();
            exp_g = (k < 6) ? (3'b001 << (k % 3)) : 3'b000;
            exp_a = AW'(12'h100 + (k % 3));
            n_checks++;
            if (bus.gnt_o !== exp_g || (k < 6 && bus.cache_addr_o !== exp_a)) begin
                n_fail++;
                $display("FAIL contention_gnt k=%0d gnt=%b addr=%h, want %b %h",
                         k, bus.gnt_o, bus.cache_addr_o, exp_g, exp_a);
            end
            if (k > 0) begin
                exp_g = 3'b001 << ((k - 1) % 3);
                n_checks++;
                if (bus.rvalid_o !== exp_g || bus.rdata_o !== exp_d) begin
                    n_fail++;
                    $display("FAIL contention_rvalid k=%0d rvalid=%b rdata=%h, want %b %h",
                             k, bus.rvalid_o, bus.rdata_o, exp_g, exp_d);
                end
            end
            tick();
        end
        drive_idle();
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd0 || bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL contention_drain outst=%0d err=%b, want 0 0", bus.outstanding_o, bus.err_o);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(12'h200 + p), '0, '1);
        for (int c = 1; c <= 4; c++) begin
            bus.req_i       = (c == 1) ? 3'b010 : 3'b011;
            bus.cache_gnt_i = (c == 4);
            mid();
            n_checks++;
            if (bus.cache_req_o !== 1'b1 || bus.cache_addr_o !== 12'h201 ||
                bus.gnt_o !== ((c == 4) ? 3'b010 : 3'b000)) begin
                n_fail++;
                $display("FAIL lock_hold c=%0d req=%b addr=%h gnt=%b, want 1 201 %b",
                         c, bus.cache_req_o, bus.cache_addr_o, bus.gnt_o,
                         (c == 4) ? 3'b010 : 3'b000);
            end
            tick();
        end
        bus.req_i = 3'b001;
        mid();
        n_checks++;
        if (bus.gnt_o !== 3'b001 || bus.cache_addr_o !== 12'h200) begin
            n_fail++;
            $display("FAIL lock_release gnt=%b addr=%h, want 001 200", bus.gnt_o, bus.cache_addr_o);
        end
        tick();
        drive_idle();
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd2 || bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_count outst=%0d err=%b, want 2 0", bus.outstanding_o, bus.err_o);
        end
    endtask

    task automatic test_full();
        logic [2:0] exp_g;
        apply_reset();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(12'h300 + p), DW'(p), '1);
        bus.req_i       = 3'b111;
        bus.cache_gnt_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mid();
            exp_g = 3'b001 << (k % 3);
            n_checks++;
            if (bus.gnt_o !== exp_g) begin
                n_fail++;
                $display("FAIL full_fill k=%0d gnt=%b, want %b", k, bus.gnt_o, exp_g);
            end
            tick();
        end
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd4 || bus.cache_req_o !== 1'b0 || bus.gnt_o !== 3'b000) begin
            n_fail++;
            $display("FAIL full_stall outst=%0d req=%b gnt=%b, want 4 0 000",
                     bus.outstanding_o, bus.cache_req_o, bus.gnt_o);
        end
        tick();
        bus.we_i[1] = 1'b1;
        mid();
        n_checks++;
        if (bus.cache_req_o !== 1'b1 || bus.cache_we_o !== 1'b1 || bus.gnt_o !== 3'b010 ||
            bus.cache_addr_o !== 12'h301) begin
            n_fail++;
            $display("FAIL full_write req=%b we=%b gnt=%b addr=%h, want 1 1 010 301",
                     bus.cache_req_o, bus.cache_we_o, bus.gnt_o, bus.cache_addr_o);
        end
        tick();
        bus.we_i[1]        = 1'b0;
        bus.cache_rvalid_i = 1'b1;
        bus.cache_rdata_i  = 64'hBEEF;
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd4 || bus.cache_req_o !== 1'b0 ||
            bus.rvalid_o !== 3'b001 || bus.rdata_o !== 64'hBEEF) begin
            n_fail++;
            $display("FAIL full_pop outst=%0d req=%b rvalid=%b rdata=%h, want 4 0 001 beef",
                     bus.outstanding_o, bus.cache_req_o, bus.rvalid_o, bus.rdata_o);
        end
        tick();
        bus.cache_rvalid_i = 1'b0;
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd3 || bus.cache_req_o !== 1'b1 || bus.gnt_o !== 3'b100) begin
            n_fail++;
            $display("FAIL full_resume outst=%0d req=%b gnt=%b, want 3 1 100",
                     bus.outstanding_o, bus.cache_req_o, bus.gnt_o);
        end
        tick();
        drive_idle();
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd4) begin
            n_fail++;
            $display("FAIL full_refill outst=%0d, want 4", bus.outstanding_o);
        end
    endtask

    task automatic test_push_pop();
        apply_reset();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(12'h400 + p), '0, '1);
        bus.cache_gnt_i = 1'b1;
        bus.req_i = 3'b001;
        tick();
        bus.req_i = 3'b010;
        tick();
        bus.req_i          = 3'b100;
        bus.cache_rvalid_i = 1'b1;
        bus.cache_rdata_i  = 64'h55;
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd2 || bus.gnt_o !== 3'b100 || bus.rvalid_o !== 3'b001 ||
            bus.rdata_o !== 64'h55) begin
            n_fail++;
            $display("FAIL pushpop_same outst=%0d gnt=%b rvalid=%b rdata=%h, want 2 100 001 55",
                     bus.outstanding_o, bus.gnt_o, bus.rvalid_o, bus.rdata_o);
        end
        tick();
        bus.req_i = 3'b000;
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd2 || bus.rvalid_o !== 3'b010) begin
            n_fail++;
            $display("FAIL pushpop_next outst=%0d rvalid=%b, want 2 010", bus.outstanding_o, bus.rvalid_o);
        end
        tick();
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd1 || bus.rvalid_o !== 3'b100) begin
            n_fail++;
            $display("FAIL pushpop_last outst=%0d rvalid=%b, want 1 100", bus.outstanding_o, bus.rvalid_o);
        end
        tick();
        drive_idle();
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd0 || bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL pushpop_empty outst=%0d err=%b, want 0 0", bus.outstanding_o, bus.err_o);
        end
    endtask

    task automatic test_errors();
        apply_reset();
        bus.cache_rvalid_i = 1'b1;
        mid();
        n_checks++;
        if (bus.rvalid_o !== 3'b000 || bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_spurious rvalid=%b err=%b, want 000 0", bus.rvalid_o, bus.err_o);
        end
        tick();
        bus.cache_rvalid_i = 1'b0;
        mid();
        n_checks++;
        if (bus.err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set err=%b, want 1", bus.err_o);
        end
        repeat (3) tick();
        mid();
        n_checks++;
        if (bus.err_o !== 1'b1 || bus.rvalid_o !== 3'b000) begin
            n_fail++;
            $display("FAIL err_sticky err=%b rvalid=%b, want 1 000", bus.err_o, bus.rvalid_o);
        end
        apply_reset();
        set_port(2, 1'b0, 12'h6A2, '0, '1);
        bus.req_i = 3'b100;
        tick();
        bus.req_i = 3'b000;
        mid();
        n_checks++;
        if (bus.cache_req_o !== 1'b1 || bus.cache_addr_o !== 12'h6A2 || bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_drop_hold req=%b addr=%h err=%b, want 1 6a2 0",
                     bus.cache_req_o, bus.cache_addr_o, bus.err_o);
        end
        tick();
        bus.cache_gnt_i = 1'b1;
        mid();
        n_checks++;
        if (bus.gnt_o !== 3'b100 || bus.err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL err_drop_gnt gnt=%b err=%b, want 100 1", bus.gnt_o, bus.err_o);
        end
        tick();
        drive_idle();
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd1 || bus.cache_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL err_drop_count outst=%0d req=%b, want 1 0", bus.outstanding_o, bus.cache_req_o);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(12'h500 + p), '1, '1);
        bus.cache_gnt_i = 1'b1;
        bus.req_i = 3'b001;
        tick();
        bus.req_i = 3'b010;
        tick();
        bus.req_i = 3'b100;
        tick();
        bus.req_i       = 3'b001;
        bus.cache_gnt_i = 1'b0;
        tick();
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd3 || bus.cache_req_o !== 1'b1 || bus.cache_addr_o !== 12'h500) begin
            n_fail++;
            $display("FAIL rstmid_setup outst=%0d req=%b addr=%h, want 3 1 500",
                     bus.outstanding_o, bus.cache_req_o, bus.cache_addr_o);
        end
        bus.req_i          = 3'b111;
        bus.cache_gnt_i    = 1'b1;
        bus.cache_rvalid_i = 1'b1;
        bus.cache_rdata_i  = 64'h1234;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (bus.cache_req_o !== 1'b0 || bus.gnt_o !== 3'b000 || bus.rvalid_o !== 3'b000 ||
            bus.rdata_o !== 64'd0 || bus.outstanding_o !== 3'd0 || bus.err_o !== 1'b0 ||
            bus.cache_addr_o !== 12'd0 || bus.cache_wdata_o !== 64'd0) begin
            n_fail++;
            $display("FAIL rstmid_async req=%b gnt=%b rv=%b rdata=%h outst=%0d err=%b addr=%h, want all 0",
                     bus.cache_req_o, bus.gnt_o, bus.rvalid_o, bus.rdata_o,
                     bus.outstanding_o, bus.err_o, bus.cache_addr_o);
        end
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        drive_idle();
        for (int p = 0; p < N; p++) set_port(p, 1'b0, AW'(12'h500 + p), '0, '1);
        bus.req_i = 3'b010;
        mid();
        n_checks++;
        if (bus.outstanding_o !== 3'd0 || bus.cache_req_o !== 1'b1 || bus.cache_addr_o !== 12'h501 ||
            bus.err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_after outst=%0d req=%b addr=%h err=%b, want 0 1 501 0",
                     bus.outstanding_o, bus.cache_req_o, bus.cache_addr_o, bus.err_o);
        end
        tick();
    endtask

    task automatic test_random();
        int            rr;
        int            lock;
        int            w;
        int            ids [$];
        logic [N-1:0]  r_req;
        logic [N-1:0]  r_we;
        logic [AW-1:0] r_addr  [N];
        logic [DW-1:0] r_wdata [N];
        logic [BW-1:0] r_be    [N];
        logic          r_gnt;
        logic          r_rv;
        logic [DW-1:0] r_rdata;
        logic [N-1:0]  exp_g;
        logic [N-1:0]  exp_rv;
        apply_reset();
        rr   = 0;
        lock = -1;
        r_req = '0;
        r_we  = '0;
        for (int p = 0; p < N; p++) begin
            r_addr[p]  = '0;
            r_wdata[p] = '0;
            r_be[p]    = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < N; p++) begin
                if (p != lock) begin
                    r_req[p]   = ($urandom_range(0, 99) < 55);
                    r_we[p]    = ($urandom_range(0, 2) == 0);
                    r_addr[p]  = AW'($urandom);
                    r_wdata[p] = {$urandom, $urandom};
                    r_be[p]    = BW'($urandom);
                end
            end
            r_gnt   = ($urandom_range(0, 99) < 60);
            r_rv    = (ids.size() > 0) && ($urandom_range(0, 99) < 35);
            r_rdata = {$urandom, $urandom};
            bus.req_i          = r_req;
            bus.cache_gnt_i    = r_gnt;
            bus.cache_rvalid_i = r_rv;
            bus.cache_rdata_i  = r_rdata;
            for (int p = 0; p < N; p++) set_port(p, r_we[p], r_addr[p], r_wdata[p], r_be[p]);

            w = lock;
            if (lock < 0) begin
                for (int i = 0; i < N; i++)
                    if (w < 0 && r_req[(rr + i) % N]) w = (rr + i) % N;
                if (w >= 0 && !r_we[w] && ids.size() == MO) w = -1;
            end
            exp_g  = (w >= 0 && r_gnt) ? N'(1) << w : '0;
            exp_rv = r_rv ? N'(1) << ids[0] : '0;

            mid();
            n_checks++;
            if (bus.cache_req_o !== (w >= 0) || bus.gnt_o !== exp_g) begin
                n_fail++;
                $display("FAIL rand_arb cyc=%0d req=%b gnt=%b, want %b %b",
                         cyc, bus.cache_req_o, bus.gnt_o, (w >= 0), exp_g);
            end
            if (w >= 0) begin
                n_checks++;
                if (bus.cache_addr_o !== r_addr[w] || bus.cache_we_o !== r_we[w] ||
                    bus.cache_wdata_o !== r_wdata[w] || bus.cache_be_o !== r_be[w]) begin
                    n_fail++;
                    $display("FAIL rand_fields cyc=%0d port=%0d addr=%h we=%b, want %h %b",
                             cyc, w, bus.cache_addr_o, bus.cache_we_o, r_addr[w], r_we[w]);
                end
            end
            n_checks++;
            if (bus.rvalid_o !== exp_rv || (r_rv && bus.rdata_o !== r_rdata)) begin
                n_fail++;
                $display("FAIL rand_return cyc=%0d rvalid=%b rdata=%h, want %b %h",
                         cyc, bus.rvalid_o, bus.rdata_o, exp_rv, r_rdata);
            end
            n_checks++;
            if (bus.outstanding_o !== 3'(ids.size()) || bus.err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_state cyc=%0d outst=%0d err=%b, want %0d 0",
                         cyc, bus.outstanding_o, bus.err_o, ids.size());
            end

            if (r_rv) void'(ids.pop_front());
            if (w >= 0 && r_gnt) begin
                if (!r_we[w]) ids.push_back(w);
                rr   = (w + 1) % N;
                lock = -1;
            end else if (w >= 0) begin
                lock = w;
            end
            tick();
        end
        drive_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive_idle();
        test_reset();
        test_contention();
        test_lock();
        test_full();
        test_push_pop();
        test_errors();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
